// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter. Selects the next fetch address from
// trap, buffered redirect, branch, jump or sequential sources. A redirect that
// arrives while the PC is frozen is held in a one-entry buffer and applied on
// the next update cycle.
module pc_gen #(
    parameter int                 WIDTH      = 32,
    parameter int                 STEP       = 4,
    parameter logic [WIDTH-1:0]   RESET_ADDR = '0,
    parameter logic [WIDTH-1:0]   TRAP_ADDR  = 'h80
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             En,
    input  logic             Stall,
    input  logic             Trap,
    input  logic             Branch_Taken,
    input  logic [WIDTH-1:0] Branch_Target,
    input  logic             Jump,
    input  logic [WIDTH-1:0] Jump_Target,
    output logic [WIDTH-1:0] IF_Addr,
    output logic             Flush,
    output logic             Pending,
    output logic             Misaligned
);

    // Low address bits that must be zero for a STEP-aligned target.
    // STEP=1 gives an all-zero mask, so nothing is ever misaligned.
    localparam logic [WIDTH-1:0] MASK   = WIDTH'(STEP - 1);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] r_addr;
    logic             r_flush;
    logic             r_mis;
    logic             r_pend_vld;
    logic             r_pend_trap;
    logic             r_pend_mis;
    logic [WIDTH-1:0] r_pend_tgt;

    logic             w_update;
    logic             w_br_mis;
    logic             w_jmp_mis;
    logic             w_new_vld;
    logic             w_new_trap;
    logic             w_new_mis;
    logic [WIDTH-1:0] w_new_tgt;
    logic [WIDTH-1:0] w_nxt_addr;
    logic             w_nxt_flush;
    logic             w_nxt_mis;
    logic             w_capture;

    assign w_update  = En & ~Stall;
    assign w_br_mis  = |(Branch_Target & MASK);
    assign w_jmp_mis = |(Jump_Target & MASK);

    // Resolve this cycle's highest-priority new request; a misaligned target
    // is turned into a trap to TRAP_ADDR and remembered as misaligned.
    always_comb begin
        w_new_vld  = 1'b0;
        w_new_trap = 1'b0;
        w_new_mis  = 1'b0;
        w_new_tgt  = TRAP_ADDR;
        if (Trap) begin
            w_new_vld  = 1'b1;
            w_new_trap = 1'b1;
        end else if (Branch_Taken) begin
            w_new_vld = 1'b1;
            if (w_br_mis) begin
                w_new_trap = 1'b1;
                w_new_mis  = 1'b1;
            end else begin
                w_new_tgt = Branch_Target;
            end
        end else if (Jump) begin
            w_new_vld = 1'b1;
            if (w_jmp_mis) begin
                w_new_trap = 1'b1;
                w_new_mis  = 1'b1;
            end else begin
                w_new_tgt = Jump_Target;
            end
        end
    end

    // Pick the winning candidate for an update cycle: trap class first
    // (buffered or new), then buffered redirect, then new redirect, then
    // the sequential address, which wraps silently at the top of the space.
    always_comb begin
        w_nxt_addr  = r_addr + STEP_W;
        w_nxt_flush = 1'b0;
        w_nxt_mis   = 1'b0;
        if (r_pend_vld && r_pend_trap) begin
            w_nxt_addr  = TRAP_ADDR;
            w_nxt_flush = 1'b1;
            w_nxt_mis   = r_pend_mis;
        end else if (w_new_vld && w_new_trap) begin
            w_nxt_addr  = TRAP_ADDR;
            w_nxt_flush = 1'b1;
            w_nxt_mis   = w_new_mis;
        end else if (r_pend_vld) begin
            w_nxt_addr  = r_pend_tgt;
            w_nxt_flush = 1'b1;
        end else if (w_new_vld) begin
            w_nxt_addr  = w_new_tgt;
            w_nxt_flush = 1'b1;
        end
    end

    // While frozen, buffer a redirect if the slot is free, or if a trap
    // arrives over a buffered non-trap; an older non-trap entry is never
    // displaced by a younger non-trap, and a buffered trap is kept as is.
    assign w_capture = w_new_vld && (!r_pend_vld || (w_new_trap && !r_pend_trap));

    // PC, pulse outputs and redirect buffer; reset overrides everything.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_addr      <= RESET_ADDR;
            r_flush     <= 1'b0;
            r_mis       <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_trap <= 1'b0;
            r_pend_mis  <= 1'b0;
            r_pend_tgt  <= RESET_ADDR;
        end else if (w_update) begin
            r_addr      <= w_nxt_addr;
            r_flush     <= w_nxt_flush;
            r_mis       <= w_nxt_mis;
            r_pend_vld  <= 1'b0;
            r_pend_trap <= 1'b0;
            r_pend_mis  <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            r_mis   <= 1'b0;
            if (w_capture) begin
                r_pend_vld  <= 1'b1;
                r_pend_trap <= w_new_trap;
                r_pend_mis  <= w_new_mis;
                r_pend_tgt  <= w_new_tgt;
            end
        end
    end

    assign IF_Addr    = r_addr;
    assign Flush      = r_flush;
    assign Pending    = r_pend_vld;
    assign Misaligned = r_mis;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed test of pc_gen with hand-computed expected values.
// A second 8-bit instance covers reset address and sequential wrap.
module tb_pc_gen;

    logic        clk;
    logic        clr;
    logic        en;
    logic        stall;
    logic        trap;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [31:0] jmp_tgt;
    logic [31:0] addr;
    logic        flush;
    logic        pend;
    logic        mis;

    logic        en8;
    logic [7:0]  addr8;
    logic        flush8;
    logic        pend8;
    logic        mis8;

    int checks = 0;
    int errors = 0;

    pc_gen u_dut (
        .Clk(clk), .Clr(clr), .En(en), .Stall(stall), .Trap(trap),
        .Branch_Taken(br), .Branch_Target(br_tgt), .Jump(jmp), .Jump_Target(jmp_tgt),
        .IF_Addr(addr), .Flush(flush), .Pending(pend), .Misaligned(mis)
    );

    pc_gen #(.WIDTH(8), .STEP(4), .RESET_ADDR(8'hFC), .TRAP_ADDR(8'h80)) u_dut8 (
        .Clk(clk), .Clr(clr), .En(en8), .Stall(1'b0), .Trap(1'b0),
        .Branch_Taken(1'b0), .Branch_Target(8'h00), .Jump(1'b0), .Jump_Target(8'h00),
        .IF_Addr(addr8), .Flush(flush8), .Pending(pend8), .Misaligned(mis8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] a, input logic f,
                           input logic p, input logic m);
        chk({tag, ".addr"}, addr, a);
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
        chk({tag, ".pend"}, {31'd0, pend}, {31'd0, p});
        chk({tag, ".mis"}, {31'd0, mis}, {31'd0, m});
    endtask

    task automatic idle();
        trap = 1'b0; br = 1'b0; jmp = 1'b0;
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; stall = 1'b0; en8 = 1'b0;
        idle(); br_tgt = '0; jmp_tgt = '0;
        tick(); tick();
        chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reset8", {24'd0, addr8}, 32'hFC);

        // Sequential after reset
        clr = 1'b0; en = 1'b1;
        tick(); chk_all("seq4", 32'h4, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("seq8", 32'h8, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("seqC", 32'hC, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("seq10", 32'h10, 1'b0, 1'b0, 1'b0);

        // Priority: trap beats branch and jump
        trap = 1'b1; br = 1'b1; br_tgt = 32'h200; jmp = 1'b1; jmp_tgt = 32'h300;
        tick(); idle();
        chk_all("prio", 32'h80, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("prio_seq", 32'h84, 1'b0, 1'b0, 1'b0);

        // Branch beats jump in the same cycle
        br = 1'b1; br_tgt = 32'h240; jmp = 1'b1; jmp_tgt = 32'h340;
        tick(); idle();
        chk_all("br_over_jmp", 32'h240, 1'b1, 1'b0, 1'b0);

        // Plain jump to 0x20
        jmp = 1'b1; jmp_tgt = 32'h20;
        tick(); idle();
        chk_all("jump", 32'h20, 1'b1, 1'b0, 1'b0);

        // Buffered redirect: older branch kept over later jump
        stall = 1'b1;
        tick(); chk_all("stall_hold", 32'h20, 1'b0, 1'b0, 1'b0);
        br = 1'b1; br_tgt = 32'h100;
        tick(); idle();
        chk_all("buf_cap", 32'h20, 1'b0, 1'b1, 1'b0);
        tick();
        jmp = 1'b1; jmp_tgt = 32'h400;
        tick(); idle();
        chk_all("buf_keep", 32'h20, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        chk_all("buf_wait", 32'h20, 1'b0, 1'b1, 1'b0);
        stall = 1'b0;
        tick(); chk_all("buf_apply", 32'h100, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("buf_after", 32'h104, 1'b0, 1'b0, 1'b0);

        // Trap overrides buffered branch
        stall = 1'b1; br = 1'b1; br_tgt = 32'h100;
        tick(); idle();
        trap = 1'b1;
        tick(); idle();
        chk_all("trap_buf", 32'h104, 1'b0, 1'b1, 1'b0);
        stall = 1'b0;
        tick(); chk_all("trap_apply", 32'h80, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("trap_after", 32'h84, 1'b0, 1'b0, 1'b0);

        // Buffered branch beats new branch on release
        stall = 1'b1; br = 1'b1; br_tgt = 32'h100;
        tick(); idle();
        stall = 1'b0; br = 1'b1; br_tgt = 32'h200;
        tick(); idle();
        chk_all("pend_over_new", 32'h100, 1'b1, 1'b0, 1'b0);

        // Misaligned branch in update cycle
        br = 1'b1; br_tgt = 32'h102;
        tick(); idle();
        chk_all("mis_now", 32'h80, 1'b1, 1'b0, 1'b1);
        tick(); chk_all("mis_after", 32'h84, 1'b0, 1'b0, 1'b0);

        // Misaligned jump buffered: flag only on application
        stall = 1'b1; jmp = 1'b1; jmp_tgt = 32'h206;
        tick(); idle();
        chk_all("mis_buf", 32'h84, 1'b0, 1'b1, 1'b0);
        stall = 1'b0;
        tick(); chk_all("mis_apply", 32'h80, 1'b1, 1'b0, 1'b1);

        // En low freezes and buffers like Stall
        en = 1'b0; br = 1'b1; br_tgt = 32'h300;
        tick(); idle();
        chk_all("en_hold", 32'h80, 1'b0, 1'b1, 1'b0);
        en = 1'b1;
        tick(); chk_all("en_apply", 32'h300, 1'b1, 1'b0, 1'b0);

        // 8-bit wrap from 0xFC to 0x00
        en8 = 1'b1;
        tick();
        chk("wrap8", {24'd0, addr8}, 32'h00);
        chk("wrap8_flush", {31'd0, flush8}, 32'd0);
        tick();
        chk("wrap8_next", {24'd0, addr8}, 32'h04);
        en8 = 1'b0;

        // Reset mid-stall discards the buffer
        stall = 1'b1; br = 1'b1; br_tgt = 32'h500;
        tick(); idle();
        chk_all("rst_pend", 32'h308, 1'b0, 1'b1, 1'b0);
        clr = 1'b1;
        tick(); chk_all("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0; stall = 1'b0;
        tick(); chk_all("rst_noredir", 32'h4, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage of the pipelined processor. Holds the current fetch address and computes the next one from sequential increment, branch, jump and trap sources, applied in fixed priority. Redirects that arrive while the PC is frozen (stall or enable low) are buffered and applied on the first update cycle, so no control transfer is lost. Misaligned targets are detected and forced to the trap vector.

## Interface
- WIDTH, 32, address width in bits (≥8).
- STEP, 4, sequential increment in bytes; power of two, ≥1.
- RESET_ADDR, 0, value of IF_Addr after reset; must be STEP-aligned.
- TRAP_ADDR, 'h80, trap vector; must be STEP-aligned.

- Clk  in  1  clock, all state updates on rising edge.
- Clr  in  1  reset, synchronous, active-high.
- En  in  1  global enable; 0 freezes PC like Stall.
- Stall  in  1  hazard stall from the hazard unit; 1 freezes PC.
- Trap  in  1  trap request, one-cycle pulse.
- Branch_Taken  in  1  resolved taken branch, one-cycle pulse.
- Branch_Target  in  WIDTH  branch target address.
- Jump  in  1  jump request, one-cycle pulse.
- Jump_Target  in  WIDTH  jump target address.
- IF_Addr  out  WIDTH  current fetch address (registered).
- Flush  out  1  registered pulse: IF_Addr was just loaded by a redirect; IF/ID must discard.
- Pending  out  1  a buffered redirect is waiting.
- Misaligned  out  1  registered pulse: a branch/jump target failed alignment and was replaced by TRAP_ADDR.

## Operation
- Update cycle: En=1 and Stall=0. Hold cycle: otherwise.
- Candidate priority (highest first): Trap (new or pending) > pending branch/jump > new Branch_Taken > new Jump > IF_Addr+STEP.
- Alignment: a branch/jump target with any of its low log2(STEP) bits set is misaligned; it is replaced by TRAP_ADDR, treated as trap class, and Misaligned pulses on the cycle the PC loads it. STEP=1 never misaligns.
- Sequential: IF_Addr+STEP modulo 2^WIDTH; all-ones region wraps to 0 with no flag.
- Update cycle: IF_Addr <= winning candidate; Flush <= 1 if winner is not sequential, else 0; pending buffer cleared.
- Hold cycle: IF_Addr holds; Flush <= 0; Misaligned <= 0. Arriving redirect (trap-resolved after alignment check) is written to the one-entry pending buffer (target + class trap/non-trap) when the buffer is empty, or when the arrival is trap class and the buffer holds non-trap. A non-trap arrival never overwrites a pending entry (older instruction wins). A trap arrival never overwrites a pending trap.
- Same-cycle multiple requests in a hold cycle: highest-priority new request is the one considered for buffering.
- Pending output = buffer valid.
- Misaligned stored in buffer and reported on application, not on capture.

## Timing
- Reset (Clr=1 at edge): IF_Addr=RESET_ADDR, Flush=0, Pending=0, Misaligned=0; overrides En, Stall and all requests. Reset mid-stall discards the pending buffer.
- Latency: request in update cycle N -> IF_Addr shows target after edge N; Flush high during cycle N+1 only.
- Request in hold cycle N, stall released in cycle M>N -> IF_Addr loads target at edge M, Flush high in cycle M+1.
- Stall and En are equivalent; both low/high combinations only matter through "update cycle".
- No combinational path from inputs to outputs.

## Test plan
- Reset: WIDTH=32, Clr=1 for 2 cycles then En=1 -> IF_Addr 0, then 4, 8, 12 on successive edges; Flush=0 throughout.
- Priority: IF_Addr=0x10, same cycle Trap=1, Branch_Taken=1 (0x200), Jump=1 (0x300) -> IF_Addr=0x80, Flush=1 next cycle; then 0x84.
- Buffered redirect: Stall=1 at IF_Addr=0x20, Branch_Taken=1 target 0x100, then Jump=1 target 0x400 two cycles later, Stall released after 3 more cycles -> Pending=1 from first capture, IF_Addr stays 0x20, then loads 0x100 (not 0x400), Flush=1, Pending=0.
- Trap overrides pending: during stall, buffered branch 0x100, then Trap=1 -> on release IF_Addr=0x80.
- Misaligned: Branch_Taken=1 target 0x102 in update cycle -> IF_Addr=0x80, Misaligned=1 and Flush=1 for one cycle.
- Wrap and reset mid-stall: WIDTH=8, RESET_ADDR=0xFC -> IF_Addr 0xFC then 0x00; separately Clr=1 with Pending=1 -> Pending=0, IF_Addr=RESET_ADDR, no later redirect applied.
